// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32I decode definitions.
// Contents:
//   - opcode constants for every RV32I major opcode that decode accepts
//   - fmt_e: instruction format classes (R/I/S/B/U/J, BAD for unknown opcodes)
//   - dec_state_e: warm-up state of the decode stage (COLD -> WARM -> RUN)
//   - get_fmt(): maps a 7-bit opcode to its format class
package rv_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef enum logic [1:0] {
    COLD,
    WARM,
    RUN
  } dec_state_e;

  function automatic fmt_e get_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_OP:                    f = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_LUI, OP_AUIPC:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/regfile.sv
// regfile: 32 x 32-bit architectural register file.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   rs1_idx, rs2_idx    read indices (combinational read ports)
//   rs1_data, rs2_data  read data; x0 always reads 0
//   wr_en, wr_idx,      single write port; writes to x0 are dropped
//   wr_data
// A read of the register being written in the same cycle returns wr_data
// (write-through), so a writeback is never lost to a concurrent decode.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_idx,
  input  logic [4:0]  rs2_idx,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [31:0] wr_data
);

  // x0 has no storage; entries 1..31 only.
  logic [31:0] regs [1:31];

  // NOTE: the array is cleared on reset because the pipeline relies on
  // architectural registers reading 0 after reset; this forces flop-based
  // storage rather than a RAM macro, which is acceptable at 31 entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples pre-edge values regardless of statement order.
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_idx != 5'd0)) begin
      regs[wr_idx] <= wr_data;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] idx);
    logic [31:0] v;
    if (idx == 5'd0) begin
      v = '0;
    end else if (wr_en && (wr_idx == idx)) begin
      v = wr_data;
    end else begin
      v = regs[idx];
    end
    return v;
  endfunction

  assign rs1_data = read_port(rs1_idx);
  assign rs2_data = read_port(rs2_idx);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: second pipeline stage of the flat RV32I core.
// Decodes the fetch pair (PC_in, IR_in), reads the register file, detects
// load-use hazards and registers a decoded bundle for EX.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   PC_in, IR_in          registered PC/instruction from fetch
//   COMP_alu              taken branch/jump in EX: squash the decode slot
//   WB_en/WB_rd/WB_data   register-file write port from writeback
//   PC_prev               to fetch: PC_in, or PC_in-4 to replay on a stall
//   stall                 combinational load-use stall
//   valid_ex ... illegal  registered EX bundle (valid_ex=0 marks a bubble)
// Optional build macro DECODE_PERF_EN adds stall_cnt / flush_cnt counters.
module decode_stage
  import rv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_in,
  input  logic [31:0] IR_in,
  input  logic        COMP_alu,
  input  logic        WB_en,
  input  logic [4:0]  WB_rd,
  input  logic [31:0] WB_data,
  output logic [31:0] PC_prev,
  output logic        stall,
  output logic        valid_ex,
  output logic [31:0] PC_ex,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [31:0] imm,
  output logic [4:0]  rd_ex,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic [6:0]  opcode,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic        is_jal,
  output logic        is_jalr,
  output logic        wr_en_ex,
  output logic        illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  // Instruction fields.
  logic [6:0] op_d;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;
  assign op_d    = IR_in[6:0];
  assign rs1_idx = IR_in[19:15];
  assign rs2_idx = IR_in[24:20];
  assign rd_idx  = IR_in[11:7];

  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;

  regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_idx  (rs1_idx),
    .rs2_idx  (rs2_idx),
    .rs1_data (rs1_rd),
    .rs2_data (rs2_rd),
    .wr_en    (WB_en),
    .wr_idx   (WB_rd),
    .wr_data  (WB_data)
  );

  // Warm-up FSM: one cycle each in COLD and WARM so fetch's first
  // registered instruction is in place before decode issues anything.
  dec_state_e state_q;
  dec_state_e state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLD:    state_d = WARM;
      WARM:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = COLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Combinational decode, immediate generation and hazard detection.
  fmt_e        fmt;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;
  logic        bubble;
  logic        wr_d;
  logic [31:0] imm_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    fmt     = get_fmt(op_d);
    use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
    use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
    wr_d    = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (rd_idx != 5'd0);
    imm_d   = '0;
    case (fmt)
      FMT_I: imm_d = {{20{IR_in[31]}}, IR_in[31:20]};
      FMT_S: imm_d = {{20{IR_in[31]}}, IR_in[31:25], IR_in[11:7]};
      FMT_B: imm_d = {{19{IR_in[31]}}, IR_in[31], IR_in[7], IR_in[30:25],
                      IR_in[11:8], 1'b0};
      FMT_U: imm_d = {IR_in[31:12], 12'b0};
      FMT_J: imm_d = {{11{IR_in[31]}}, IR_in[31], IR_in[19:12], IR_in[20],
                      IR_in[30:21], 1'b0};
      default: imm_d = '0;
    endcase

    // Only a real load in EX can hazard; bubbles carry is_load = 0.
    hazard = valid_ex && is_load && (rd_ex != 5'd0) &&
             ((use_rs1 && (rs1_idx == rd_ex)) ||
              (use_rs2 && (rs2_idx == rd_ex)));
    // A flush discards IR_in anyway, so it overrides the stall.
    stall   = (state_q == RUN) && hazard && !COMP_alu;
    PC_prev = stall ? (PC_in - 32'd4) : PC_in;
    bubble  = (state_q != RUN) || COMP_alu || stall;
  end

  // EX bundle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_ex  <= 1'b0;
      PC_ex     <= '0;
      rs1_val   <= '0;
      rs2_val   <= '0;
      imm       <= '0;
      rd_ex     <= '0;
      funct3    <= '0;
      funct7b5  <= 1'b0;
      opcode    <= '0;
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      is_branch <= 1'b0;
      is_jal    <= 1'b0;
      is_jalr   <= 1'b0;
      wr_en_ex  <= 1'b0;
      illegal   <= 1'b0;
    end else if (bubble || (fmt == FMT_BAD)) begin
      // Bubbles and illegal instructions never issue; data fields hold.
      valid_ex  <= 1'b0;
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      is_branch <= 1'b0;
      is_jal    <= 1'b0;
      is_jalr   <= 1'b0;
      wr_en_ex  <= 1'b0;
      illegal   <= !bubble;
      if (!bubble) begin
        PC_ex <= PC_in;
      end
    end else begin
      valid_ex  <= 1'b1;
      PC_ex     <= PC_in;
      rs1_val   <= rs1_rd;
      rs2_val   <= rs2_rd;
      imm       <= imm_d;
      rd_ex     <= rd_idx;
      funct3    <= IR_in[14:12];
      funct7b5  <= IR_in[30];
      opcode    <= op_d;
      is_load   <= (op_d == OP_LOAD);
      is_store  <= (op_d == OP_STORE);
      is_branch <= (op_d == OP_BRANCH);
      is_jal    <= (op_d == OP_JAL);
      is_jalr   <= (op_d == OP_JALR);
      wr_en_ex  <= wr_d;
      illegal   <= 1'b0;
    end
  end

`ifdef DECODE_PERF_EN
  // Free-running event counters; wrap modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (COMP_alu && (state_q == RUN)) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
// Directed scenarios followed by randomized instruction streams, compared
// cycle by cycle against a behavioural model of the decode rules.
// Honours DECODE_PERF_EN (checks the counters when defined).
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] PC_in;
  logic [31:0] IR_in;
  logic        COMP_alu;
  logic        WB_en;
  logic [4:0]  WB_rd;
  logic [31:0] WB_data;
  logic [31:0] PC_prev;
  logic        stall;
  logic        valid_ex;
  logic [31:0] PC_ex;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic [4:0]  rd_ex;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [6:0]  opcode;
  logic        is_load;
  logic        is_store;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic        wr_en_ex;
  logic        illegal;
`ifdef DECODE_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .PC_in     (PC_in),
    .IR_in     (IR_in),
    .COMP_alu  (COMP_alu),
    .WB_en     (WB_en),
    .WB_rd     (WB_rd),
    .WB_data   (WB_data),
    .PC_prev   (PC_prev),
    .stall     (stall),
    .valid_ex  (valid_ex),
    .PC_ex     (PC_ex),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .imm       (imm),
    .rd_ex     (rd_ex),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .opcode    (opcode),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_branch (is_branch),
    .is_jal    (is_jal),
    .is_jalr   (is_jalr),
    .wr_en_ex  (wr_en_ex),
    .illegal   (illegal)
`ifdef DECODE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    bit          f7;
    logic [6:0]  op;
    bit          ld, st, br, jl, jr, wr, ill;
  } ex_t;

  ex_t         m;
  logic [31:0] mreg [32];
  int          phase;          // edges since reset, saturating at 2
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;
  logic        obs_stall;
  logic [31:0] obs_pcprev;
  bit          last_stall;

  // Decode rules expressed per opcode; immediates via field arithmetic.
  function automatic void mdec(input logic [31:0] ir, output bit legal,
                               output bit u1, output bit u2, output bit wr,
                               output logic [31:0] iv);
    int v;
    legal = 1; u1 = 0; u2 = 0; wr = 0; v = 0;
    case (ir[6:0])
      7'h33: begin u1 = 1; u2 = 1; wr = 1; v = 0; end
      7'h13, 7'h03, 7'h67: begin
        u1 = 1; wr = 1;
        v = ir[31:20]; if (ir[31]) v -= 4096;
      end
      7'h23: begin
        u1 = 1; u2 = 1;
        v = ir[31:25] * 32 + ir[11:7]; if (ir[31]) v -= 4096;
      end
      7'h63: begin
        u1 = 1; u2 = 1;
        v = ir[11:8] * 2 + ir[30:25] * 32 + ir[7] * 2048;
        if (ir[31]) v -= 4096;
      end
      7'h37, 7'h17: begin wr = 1; v = ir & 32'hFFFF_F000; end
      7'h6F: begin
        wr = 1;
        v = ir[30:21] * 2 + ir[20] * 2048 + ir[19:12] * 4096;
        if (ir[31]) v -= (1 << 20);
      end
      default: legal = 0;
    endcase
    if (ir[11:7] == 5'd0) wr = 0;
    iv = v;
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (WB_en && WB_rd == idx) return WB_data;
    return mreg[idx];
  endfunction

  task automatic check_bundle(input string tag);
    check({tag, ".valid"}, valid_ex, m.valid);
    check({tag, ".pc"}, PC_ex, m.pc);
    check({tag, ".rs1"}, rs1_val, m.r1);
    check({tag, ".rs2"}, rs2_val, m.r2);
    check({tag, ".imm"}, imm, m.imm);
    check({tag, ".rd"}, rd_ex, m.rd);
    check({tag, ".f3"}, funct3, m.f3);
    check({tag, ".f7b5"}, funct7b5, m.f7);
    check({tag, ".op"}, opcode, m.op);
    check({tag, ".flags"},
          {is_load, is_store, is_branch, is_jal, is_jalr, wr_en_ex},
          {m.ld, m.st, m.br, m.jl, m.jr, m.wr});
    check({tag, ".illegal"}, illegal, m.ill);
`ifdef DECODE_PERF_EN
    check({tag, ".stall_cnt"}, stall_cnt, m_stall_cnt);
    check({tag, ".flush_cnt"}, flush_cnt, m_flush_cnt);
`endif
  endtask

  // One clock cycle: drive, check combinational outputs, advance model,
  // clock, check the registered bundle. Entered and left at negedge.
  task automatic step(input string tag, input logic r, input logic [31:0] pc,
                      input logic [31:0] ir, input logic comp,
                      input logic we, input logic [4:0] wrd,
                      input logic [31:0] wd);
    bit legal, u1, u2, wr, hz, exp_stall, run;
    logic [31:0] iv;
    ex_t nx;
    rst = r; PC_in = pc; IR_in = ir; COMP_alu = comp;
    WB_en = we; WB_rd = wrd; WB_data = wd;
    #1;
    mdec(ir, legal, u1, u2, wr, iv);
    run = (phase >= 2);
    hz = m.valid && m.ld && (m.rd != 0) &&
         ((u1 && ir[19:15] == m.rd) || (u2 && ir[24:20] == m.rd));
    exp_stall = run && hz && !comp;
    obs_stall = stall;
    obs_pcprev = PC_prev;
    if (!r) begin
      check({tag, ".stall"}, stall, exp_stall);
      check({tag, ".pc_prev"}, PC_prev, exp_stall ? pc - 32'd4 : pc);
    end
    nx = m;
    if (r) begin
      nx = '{default: 0};
      phase = 0;
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (exp_stall) m_stall_cnt++;
      if (run && comp) m_flush_cnt++;
      if (!run || comp || exp_stall || !legal) begin
        nx.valid = 0;
        {nx.ld, nx.st, nx.br, nx.jl, nx.jr, nx.wr} = '0;
        nx.ill = run && !comp && !exp_stall && !legal;
        if (nx.ill) nx.pc = pc;
      end else begin
        nx.valid = 1; nx.pc = pc;
        nx.r1 = mread(ir[19:15]); nx.r2 = mread(ir[24:20]);
        nx.imm = iv; nx.rd = ir[11:7]; nx.f3 = ir[14:12];
        nx.f7 = ir[30]; nx.op = ir[6:0];
        nx.ld = (ir[6:0] == 7'h03); nx.st = (ir[6:0] == 7'h23);
        nx.br = (ir[6:0] == 7'h63); nx.jl = (ir[6:0] == 7'h6F);
        nx.jr = (ir[6:0] == 7'h67); nx.wr = wr; nx.ill = 0;
      end
      if (phase < 2) phase++;
    end
    last_stall = exp_stall;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) mreg[i] = '0;
    end else if (we && wrd != 0) begin
      mreg[wrd] = wd;
    end
    m = nx;
    #1;
    check_bundle(tag);
    @(negedge clk);
  endtask

  localparam logic [31:0] ADDI_X1_5  = 32'h0050_0093;
  localparam logic [31:0] LW_X2_X1   = 32'h0000_A103;
  localparam logic [31:0] ADD_X3_X2  = 32'h0021_01B3;
  localparam logic [31:0] ADD_X6_X5  = 32'h0002_8333;
  localparam logic [31:0] ADD_X7_X0  = 32'h0000_03B3;
  localparam logic [31:0] BEQ_M4     = 32'hFE00_0EE3;
  localparam logic [31:0] LUI_X1     = 32'h1234_50B7;
  localparam logic [31:0] BAD_OP     = 32'h0000_007F;

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] pc, ir;
    logic        comp, r;
    m = '{default: 0};
    phase = 0; m_stall_cnt = 0; m_flush_cnt = 0; last_stall = 0;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    rst = 1; PC_in = 0; IR_in = 0; COMP_alu = 0;
    WB_en = 0; WB_rd = 0; WB_data = 0;

    // Reset and warm-up: two bubbles even with a legal instruction present.
    step("reset", 1, 0, ADDI_X1_5, 0, 0, 0, 0);
    check("reset_valid", valid_ex, 0);
    step("cold", 0, 0, ADDI_X1_5, 0, 0, 0, 0);
    check("cold_valid", valid_ex, 0);
    step("warm", 0, 4, ADDI_X1_5, 0, 0, 0, 0);
    check("warm_valid", valid_ex, 0);

    // addi x1,x0,5 at PC 8.
    step("addi", 0, 32'h8, ADDI_X1_5, 0, 0, 0, 0);
    check("addi_valid", valid_ex, 1);
    check("addi_imm", imm, 32'd5);
    check("addi_rd", rd_ex, 32'd1);
    check("addi_wr", wr_en_ex, 1);
    check("addi_pc", PC_ex, 32'h8);

    // Load-use: lw x2 then add x3,x2,x2 -> one stall, then issue.
    step("lw", 0, 32'hC, LW_X2_X1, 0, 0, 0, 0);
    step("lu_stall", 0, 32'h10, ADD_X3_X2, 0, 0, 0, 0);
    check("lu_stall_flag", obs_stall, 1);
    check("lu_pc_prev", obs_pcprev, 32'hC);
    check("lu_bubble", valid_ex, 0);
    step("lu_replay", 0, 32'h10, ADD_X3_X2, 0, 0, 0, 0);
    check("lu_replay_stall", obs_stall, 0);
    check("lu_replay_valid", valid_ex, 1);

    // Flush beats stall.
    step("lw2", 0, 32'h14, LW_X2_X1, 0, 0, 0, 0);
    step("flush", 0, 32'h18, ADD_X3_X2, 1, 0, 0, 0);
    check("flush_stall", obs_stall, 0);
    check("flush_pc_prev", obs_pcprev, 32'h18);
    check("flush_bubble", valid_ex, 0);

    // Write-through bypass.
    step("bypass", 0, 32'h1C, ADD_X6_X5, 0, 1, 5'd5, 32'hDEAD_BEEF);
    check("bypass_rs1", rs1_val, 32'hDEAD_BEEF);
    step("x5_held", 0, 32'h20, ADD_X6_X5, 0, 0, 0, 0);
    check("x5_held_rs1", rs1_val, 32'hDEAD_BEEF);

    // x0 ignores writes, both during the write and afterwards.
    step("x0_wr", 0, 32'h24, ADD_X7_X0, 0, 1, 5'd0, 32'h1234_5678);
    check("x0_wr_rs1", rs1_val, 32'd0);
    step("x0_rd", 0, 32'h28, ADD_X7_X0, 0, 0, 0, 0);
    check("x0_rd_rs1", rs1_val, 32'd0);

    // Immediates and illegal opcode.
    step("beq", 0, 32'h2C, BEQ_M4, 0, 0, 0, 0);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    step("lui", 0, 32'h30, LUI_X1, 0, 0, 0, 0);
    check("lui_imm", imm, 32'h1234_5000);
    step("bad", 0, 32'h34, BAD_OP, 0, 0, 0, 0);
    check("bad_illegal", illegal, 1);
    check("bad_valid", valid_ex, 0);
    check("bad_pc", PC_ex, 32'h34);
    step("bad_clear", 0, 32'h38, ADDI_X1_5, 0, 0, 0, 0);
    check("bad_clear_illegal", illegal, 0);

    // Reset in the middle of a stall: dropped, warm-up restarts.
    step("mid_lw", 0, 32'h3C, LW_X2_X1, 0, 0, 0, 0);
    step("mid_rst", 1, 32'h40, ADD_X3_X2, 0, 0, 0, 0);
    check("mid_rst_valid", valid_ex, 0);
    check("mid_rst_pc", PC_ex, 0);
    step("mid_cold", 0, 32'h40, ADD_X3_X2, 0, 0, 0, 0);
    check("mid_cold_stall", obs_stall, 0);
    step("mid_warm", 0, 32'h44, ADDI_X1_5, 0, 0, 0, 0);
    check("mid_warm_valid", valid_ex, 0);

    // Randomized streams with small register indices to provoke hazards.
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h7F};
    pc = 32'h100;
    ir = ADDI_X1_5;
    for (int n = 0; n < 600; n++) begin
      if (!last_stall) begin
        pc = pc + 32'd4;
        ir = {$urandom_range(0, 127) == 0 ? 7'h00 : 7'($urandom),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)),
              ops[$urandom_range(0, 9)]};
        if ($urandom_range(0, 2) == 0) ir[6:0] = 7'h03;
      end
      comp = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 149) == 0);
      step("rand", r, pc, ir, comp, 1'($urandom), 5'($urandom_range(0, 4)),
           $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
